// File: rtl/i2c_phase_gen.sv
// Programmable I2C phase tick generator: PHASES ticks per SCL period, run-time
// divisor with period-aligned updates, stretch freeze and synchronous clear.
module i2c_phase_gen #(
  parameter int SYS_CLK_FREQ = 50_000_000,
  parameter int I2C_FREQ     = 100_000,
  parameter int PHASES       = 4,
  parameter int DIV_W        = 16,
  parameter int DEF_DIV      = SYS_CLK_FREQ / (I2C_FREQ * PHASES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      sync_clr,
  input  logic                      stretch,
  input  logic                      div_load,
  input  logic [DIV_W-1:0]          div_value,
  output logic                      tick,
  output logic [$clog2(PHASES)-1:0] phase,
  output logic                      period_done,
  output logic [DIV_W-1:0]          div_active
);

  localparam int               PW      = $clog2(PHASES);
  localparam logic [PW-1:0]    PH_LAST = PW'(PHASES - 1);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEF_DIV);

  if (PHASES < 2) begin : g_bad_phases
    $error("i2c_phase_gen: PHASES must be >= 2");
  end
  if (DEF_DIV < 1 || longint'(DEF_DIV) >= (longint'(1) << DIV_W)) begin : g_bad_div
    $error("i2c_phase_gen: DEF_DIV out of range for DIV_W");
  end

  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] div_pend, div_pend_nxt, div_act_nxt, div_req;
  logic             pend_vld, pend_vld_nxt;
  logic [PW-1:0]    phase_nxt;
  logic             tick_nxt, pd_nxt;
  logic             clear, wrap, xfer;

  // A requested divisor of 0 would stall the counter, so it is promoted to 1.
  assign div_req = (div_value == '0) ? DIV_W'(1) : div_value;
  assign clear   = ~en | sync_clr;
  assign wrap    = cnt >= (div_active - DIV_W'(1));

  always_comb begin
    cnt_nxt   = cnt;
    phase_nxt = phase;
    tick_nxt  = 1'b0;
    pd_nxt    = 1'b0;
    xfer      = 1'b0;
    if (clear) begin
      cnt_nxt   = '0;
      phase_nxt = '0;
      xfer      = 1'b1;
    end else if (!stretch) begin
      if (wrap) begin
        cnt_nxt   = '0;
        phase_nxt = (phase == PH_LAST) ? '0 : phase + PW'(1);
        tick_nxt  = 1'b1;
        pd_nxt    = (phase == PH_LAST);
        xfer      = (phase == PH_LAST);
      end else begin
        cnt_nxt = cnt + DIV_W'(1);
      end
    end
  end

  // Divisor only changes at a period boundary or while cleared, never mid-period.
  always_comb begin
    div_act_nxt  = div_active;
    div_pend_nxt = div_pend;
    pend_vld_nxt = pend_vld;
    if (xfer) begin
      if (div_load) begin
        div_act_nxt  = div_req;
        pend_vld_nxt = 1'b0;
      end else if (pend_vld) begin
        div_act_nxt  = div_pend;
        pend_vld_nxt = 1'b0;
      end
    end else if (div_load) begin
      div_pend_nxt = div_req;
      pend_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      phase       <= '0;
      tick        <= 1'b0;
      period_done <= 1'b0;
      div_active  <= DIV_RST;
      div_pend    <= DIV_RST;
      pend_vld    <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      phase       <= phase_nxt;
      tick        <= tick_nxt;
      period_done <= pd_nxt;
      div_active  <= div_act_nxt;
      div_pend    <= div_pend_nxt;
      pend_vld    <= pend_vld_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_phase_gen.sv
// Bench for i2c_phase_gen: directed scenarios with literal expectations plus
// randomized control traffic, all checked every cycle against a behavioural model.
module tb_i2c_phase_gen;

  localparam int PHASES = 4;
  localparam int DIV_W  = 16;
  localparam int DEF    = 125;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             sync_clr = 1'b0;
  logic             stretch = 1'b0;
  logic             div_load = 1'b0;
  logic [DIV_W-1:0] div_value = '0;
  logic             tick;
  logic [1:0]       phase;
  logic             period_done;
  logic [DIV_W-1:0] div_active;

  int checks = 0;
  int errors = 0;

  i2c_phase_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .stretch(stretch),
    .div_load(div_load), .div_value(div_value), .tick(tick), .phase(phase),
    .period_done(period_done), .div_active(div_active)
  );

  always #5 clk = ~clk;

  // Behavioural model: elapsed clocks within the current phase, phase index,
  // and the divisor in force / waiting for the next period boundary.
  int  m_elapsed, m_phase, m_div, m_pend;
  bit  m_has_pend, m_tick, m_pd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_elapsed = 0; m_phase = 0; m_tick = 0; m_pd = 0;
      m_div = DEF; m_has_pend = 0; m_pend = DEF;
    end else begin
      int req;
      bit boundary;
      req = (div_value == 0) ? 1 : int'(div_value);
      boundary = 0;
      m_tick = 0;
      m_pd = 0;
      if (!en || sync_clr) begin
        m_elapsed = 0;
        m_phase = 0;
        boundary = 1;
      end else if (!stretch) begin
        m_elapsed++;
        if (m_elapsed == m_div) begin
          m_elapsed = 0;
          m_phase = (m_phase + 1) % PHASES;
          m_tick = 1;
          m_pd = (m_phase == 0);
          boundary = m_pd;
        end
      end
      if (boundary) begin
        if (div_load) m_div = req;
        else if (m_has_pend) m_div = m_pend;
        m_has_pend = 0;
      end else if (div_load) begin
        m_pend = req;
        m_has_pend = 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("tick", int'(tick), int'(m_tick));
    check("phase", int'(phase), m_phase);
    check("period_done", int'(period_done), int'(m_pd));
    check("div_active", int'(div_active), m_div);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Count rising edges until tick (want_pd=0) or period_done (want_pd=1); bounded.
  task automatic wait_evt(input bit want_pd, input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(want_pd ? period_done : tick) && n < limit);
  endtask

  int n;

  initial begin
    step(3);
    #1;
    check("reset_tick", int'(tick), 0);
    check("reset_div", int'(div_active), DEF);

    // Defaults from reset release
    @(posedge clk); #2;
    rst_n = 1'b1;
    en = 1'b1;
    wait_evt(0, 400, n);
    check("first_tick_latency", n, 125);
    check("first_tick_phase", int'(phase), 1);
    wait_evt(1, 1000, n);
    check("first_pd_latency", n, 375);
    check("pd_phase", int'(phase), 0);

    // Divisor 25 requested mid-period, applied at the next period boundary
    wait_evt(0, 400, n);
    step(75);
    div_load = 1'b1; div_value = 16'd25;
    step(1);
    div_load = 1'b0;
    check("div_held", int'(div_active), 125);
    wait_evt(1, 1000, n);
    check("pd_after_load", n, 299);
    check("div_applied", int'(div_active), 25);
    wait_evt(0, 400, n);
    check("tick_25", n, 25);
    wait_evt(1, 1000, n);
    check("pd_100", n, 75);

    // Stretch 10 cycles in phase 2 with cnt=10
    wait_evt(0, 400, n);
    wait_evt(0, 400, n);
    check("stretch_phase_pre", int'(phase), 2);
    step(10);
    stretch = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("stretch_hold_phase", int'(phase), 2);
      check("stretch_no_tick", int'(tick), 0);
    end
    stretch = 1'b0;
    wait_evt(0, 400, n);
    check("stretch_resume", n, 15);
    check("stretch_div", int'(div_active), 25);

    // sync_clr with stretch mid-phase 3
    step(5);
    sync_clr = 1'b1; stretch = 1'b1;
    step(1);
    sync_clr = 1'b0; stretch = 1'b0;
    check("clr_phase", int'(phase), 0);
    check("clr_tick", int'(tick), 0);
    wait_evt(0, 400, n);
    check("clr_first_tick", n, 25);

    // Divisor 0 loaded while disabled -> 1
    en = 1'b0;
    div_load = 1'b1; div_value = 16'd0;
    step(1);
    div_load = 1'b0;
    check("div_zero", int'(div_active), 1);
    en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      check("div1_tick", int'(tick), 1);
      check("div1_phase", int'(phase), i % 4);
      check("div1_pd", int'(period_done), int'(i % 4 == 0));
    end

    // Async reset with a pending divisor
    en = 1'b0;
    div_load = 1'b1; div_value = 16'd50;
    step(1);
    div_load = 1'b0; en = 1'b1;
    wait_evt(0, 400, n);
    wait_evt(0, 400, n);
    div_load = 1'b1; div_value = 16'd9;
    step(1);
    div_load = 1'b0;
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_tick", int'(tick), 0);
    check("async_phase", int'(phase), 0);
    check("async_div", int'(div_active), DEF);
    @(posedge clk); #2;
    rst_n = 1'b1;
    wait_evt(0, 400, n);
    check("post_reset_tick", n, 125);
    check("pending_dropped", int'(div_active), DEF);

    // Randomized control traffic
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      en        = ($urandom % 25) != 0;
      sync_clr  = ($urandom % 60) == 0;
      stretch   = ($urandom % 8) == 0;
      div_load  = ($urandom % 30) == 0;
      div_value = DIV_W'($urandom % 7);
    end
    @(posedge clk); #2;
    en = 1'b0; sync_clr = 1'b0; stretch = 1'b0; div_load = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_phase_gen.md
Name: i2c_phase_gen

Overview:
Parametrised successor to the fixed-rate I2C tick generator. It produces PHASES evenly spaced ticks per SCL period, with a phase index and a period-boundary strobe. The divisor is programmable at run time, so one instance serves standard, fast and fast-plus modes. Stretch and synchronous-clear inputs let the I2C master FSM stall or realign timing, for example during SCL clock stretching or on START.

Parameters:
SYS_CLK_FREQ, 50_000_000, system clock frequency in Hz
I2C_FREQ, 100_000, SCL frequency that sets the reset-default divisor
PHASES, 4, ticks per SCL period; must be >= 2
DIV_W, 16, width of the divisor and the cycle counter
DEF_DIV, SYS_CLK_FREQ/(I2C_FREQ*PHASES), reset divisor (125 at defaults); elaboration error if 0 or >= 2**DIV_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; low holds the block cleared
sync_clr  in  1  one-cycle synchronous restart of counter and phase
stretch  in  1  freeze: counter and phase hold, tick suppressed
div_load  in  1  pulse; capture div_value as the pending divisor
div_value  in  DIV_W  requested system clocks per tick
tick  out  1  one-cycle pulse on entry to a new phase
phase  out  $clog2(PHASES)  index of the current phase, 0..PHASES-1
period_done  out  1  one-cycle pulse, coincident with the tick that enters phase 0
div_active  out  DIV_W  divisor currently in use

Behaviour:
- Reset (rst_n low, asynchronous):
  - Counter and phase go to 0.
  - tick and period_done go to 0.
  - div_active = DEF_DIV; pending flag cleared.
- All outputs are registered; no combinational path from input to output.
- "run" = en & ~sync_clr & ~stretch.
- Counter cnt (DIV_W bits) counts 0..div_active-1.
  - Edge with run and cnt == div_active-1:
    - cnt <= 0
    - phase <= (phase+1) mod PHASES
    - tick <= 1
    - period_done <= 1 if the new phase is 0
  - Edge with run and cnt < div_active-1: cnt <= cnt+1; tick and period_done <= 0.
- Latency: with en high from a cleared state, the first tick is visible after D = div_active rising edges. Ticks then occur every D cycles, and period_done every D*PHASES cycles.
- Phase sequence from cleared: the first tick enters phase 1. period_done accompanies the PHASES-th tick.
- stretch high (en high):
  - cnt and phase hold; tick and period_done are 0.
  - On release, counting resumes from the held cnt. The pending tick is delayed by exactly the number of stretch cycles.
- en low or sync_clr high: on the next edge, cnt = 0, phase = 0, tick = 0, period_done = 0. sync_clr overrides stretch and en.
- Divisor load:
  - div_load captures div_value into the pending register and sets the pending flag. A value of 0 is stored as 1.
  - A second div_load before the pending value is applied overwrites it (last write wins).
  - The pending value transfers to div_active (flag cleared) on either of:
    - the same edge that asserts period_done, or
    - any edge where en is low or sync_clr is high.
  - div_load on the same edge as either transfer condition: the new div_value is applied directly.
  - The divisor never changes mid-period while running, so SCL high/low widths stay consistent within a period.
- div_active = 1: tick is high every cycle while running, and phase advances every cycle.
- cnt compares against the div_active in force at that edge; no wrap beyond div_active-1 is possible.
- Reset asserted mid-period: all state is cleared immediately. Operation restarts from phase 0 with DEF_DIV; any pending divisor is lost.

Test Plan:
- Defaults, en held high from reset release -> tick after 125 cycles, then every 125; phase steps 1,2,3,0; period_done every 500 cycles, coincident with phase=0.
- Running at div 125: div_load=25 at cycle 200 -> div_active stays 125 until the period_done at cycle 500, then ticks every 25 cycles and period_done every 100.
- stretch high for 10 cycles starting with cnt=60 in phase 2 -> phase holds at 2, no tick; next tick at 125+10 cycles after the prior tick; div_active unchanged.
- en low, div_load with div_value=0, then en high -> div_active=1; tick high every cycle; phase 1,2,3,0 repeating; period_done every 4th cycle.
- sync_clr pulse mid-phase 3 with stretch also high -> next cycle cnt=0, phase=0, no tick; first tick 125 cycles after sync_clr deasserts.
- rst_n asserted asynchronously between clock edges while in phase 2 with a pending divisor -> outputs zero immediately; after release, div_active=125 and the pending value is discarded.
